// File: rtl/if_prefetch_unit_pkg.sv
`default_nettype none
// Shared types and constants for the instruction prefetch unit and its queue.
package if_prefetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_unit_fetch_fifo.sv
`default_nettype none
// Prefetch queue: synchronous FIFO of {instruction, PC+4} entries.
// Flush overrides push and pop; the head reads as a NOP with zero PC+4 when empty.
module if_prefetch_unit_fetch_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  fetch_entry_t            data_i,
  output fetch_entry_t            head_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_i & (count_q != FULL_C) & ~flush_i;
    do_pop   = pop_i & (count_q != '0) & ~flush_i;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q]
                                   : '{instr: NOP_INSTR, pc_plus4: '0};
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// Instruction-fetch front end: owns the PC, keeps one fetch in flight to a
// handshaked memory, and queues {instr, PC+4} for the decode stage.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    redirect_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  output logic                    imem_req_o,
  output logic [ADDR_W-1:0]       imem_addr_o,
  input  logic                    imem_ready_i,
  input  logic                    imem_rvalid_i,
  input  logic [INSTR_W-1:0]      imem_rdata_i,
  output logic                    out_valid_o,
  output logic [INSTR_W-1:0]      out_instr_o,
  output logic [ADDR_W-1:0]       out_pc_plus4_o,
  input  logic                    out_ready_i,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;
  logic              has_space;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign has_space   = (count < FULL_C);
  assign pop         = out_valid_o & out_ready_i;
  assign count_after = count + CW'(1) - CW'(pop);

  assign push_entry.instr    = imem_rdata_i;
  assign push_entry.pc_plus4 = fetch_pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (has_space) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!has_space) begin
          state_d = ST_IDLE;
        end else begin
          imem_req_o = 1'b1;
          if (imem_ready_i) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after < FULL_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect wins over everything; any accepted-but-unanswered fetch is stale.
    if (redirect_i) begin
      push       = 1'b0;
      fetch_pc_d = redirect_pc_i & ~32'h3;
      case (state_q)
        ST_REQ:           state_d = (imem_req_o && imem_ready_i) ? ST_DROP : ST_REQ;
        ST_WAIT, ST_DROP: state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
        default:          state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_prefetch_unit_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_addr_o    = fetch_pc_q;
  assign out_valid_o    = (count != '0) & ~redirect_i;
  assign out_instr_o    = head.instr;
  assign out_pc_plus4_o = head.pc_plus4;
  assign count_o        = count;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// Bench for if_prefetch_unit: directed scenarios and randomized traffic checked
// against a transaction-level model of the in-order fetch stream.
module tb_if_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_ready_i;
  logic          imem_rvalid_i;
  logic [31:0]   imem_rdata_i;
  logic          out_valid_o;
  logic [31:0]   out_instr_o;
  logic [31:0]   out_pc_plus4_o;
  logic          out_ready_i;
  logic [CW-1:0] count_o;

  always #5 clk_i = ~clk_i;

  if_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (imem_ready_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .out_valid_o    (out_valid_o),
    .out_instr_o    (out_instr_o),
    .out_pc_plus4_o (out_pc_plus4_o),
    .out_ready_i    (out_ready_i),
    .count_o        (count_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus knobs
  int rdy_pct, ordy_pct, lat_lo, lat_hi;

  // Memory model: at most one request, answered after a random latency
  bit          mem_pending;
  int          mem_wait;
  logic [31:0] pend_addr;
  int          pend_epoch;
  int          epoch;

  // Fetch-stream model: addresses queued for decode, next expected fetch address
  logic [31:0] mq[$];
  logic [31:0] exp_next;
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];
  int          hs_total;
  bit          prev_stall, prev_redir;
  logic [31:0] prev_addr;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, update model.
  task automatic step(input logic redir, input logic [31:0] tgt);
    logic hs, pop, rv, accept, exp_valid;
    rv            = mem_pending && (mem_wait == 0);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? imem_word(pend_addr) : $urandom();
    imem_ready_i  = ($urandom_range(99) < rdy_pct);
    out_ready_i   = ($urandom_range(99) < ordy_pct);
    redirect_i    = redir;
    redirect_pc_i = tgt;
    #1;
    exp_valid = (mq.size() != 0) && !redir;
    check("out_valid", 32'(out_valid_o), 32'(exp_valid));
    check("count", 32'(count_o), 32'(mq.size()));
    if (mq.size() != 0) begin
      check("head_pc_plus4", out_pc_plus4_o, mq[0] + 32'd4);
      check("head_instr", out_instr_o, imem_word(mq[0]));
    end else begin
      check("empty_pc_plus4", out_pc_plus4_o, 32'h0);
      check("empty_instr", out_instr_o, 32'h0);
    end
    if (imem_req_o) begin
      check("one_outstanding", 32'(mem_pending), 32'h0);
      check("addr_aligned", 32'(imem_addr_o[1:0]), 32'h0);
    end
    if (prev_stall && !prev_redir) begin
      check("stall_req_held", 32'(imem_req_o), 32'h1);
      check("stall_addr_held", imem_addr_o, prev_addr);
    end
    hs     = imem_req_o && imem_ready_i;
    pop    = exp_valid && out_ready_i;
    accept = rv && !redir && (pend_epoch == epoch);
    if (pop) begin
      pop_log.push_back(mq[0] + 32'd4);
      void'(mq.pop_front());
    end
    if (accept) begin
      check("fetch_order", pend_addr, exp_next);
      mq.push_back(pend_addr);
      exp_next = exp_next + 32'd4;
    end
    if (rv) mem_pending = 1'b0;
    else if (mem_pending) mem_wait--;
    if (hs) begin
      mem_pending = 1'b1;
      pend_addr   = imem_addr_o;
      pend_epoch  = epoch;
      mem_wait    = int'($urandom_range(lat_hi, lat_lo)) - 1;
      hs_log.push_back(imem_addr_o);
      hs_total++;
    end
    if (redir) begin
      mq.delete();
      exp_next = tgt & ~32'h3;
      epoch++;
    end
    prev_stall = imem_req_o && !imem_ready_i;
    prev_addr  = imem_addr_o;
    prev_redir = redir;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asserts reset between clock edges, checks reset values, releases on a falling edge.
  task automatic do_reset();
    #2;
    rst_i         = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    out_ready_i   = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_instr", out_instr_o, 32'h0);
    check("rst_pc_plus4", out_pc_plus4_o, 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    mem_pending = 1'b0;
    mq.delete();
    hs_log.delete();
    pop_log.delete();
    exp_next   = RESET_PC;
    epoch++;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic wait_hs(input int n);
    int b = 0;
    while (hs_log.size() < n && b < 100) begin
      step(1'b0, 32'h0);
      b++;
    end
    check("wait_hs_timeout", 32'(hs_log.size() >= n), 32'h1);
  endtask

  task automatic wait_pop(input int n);
    int b = 0;
    while (pop_log.size() < n && b < 100) begin
      step(1'b0, 32'h0);
      b++;
    end
    check("wait_pop_timeout", 32'(pop_log.size() >= n), 32'h1);
  endtask

  task automatic redirect_check(input logic [31:0] tgt, input string tag);
    step(1'b1, tgt);
    hs_log.delete();
    pop_log.delete();
    check({tag, "_count_flushed"}, 32'(count_o), 32'h0);
    wait_hs(1);
    if (hs_log.size() > 0) check({tag, "_first_addr"}, hs_log[0], tgt & ~32'h3);
    wait_pop(1);
    if (pop_log.size() > 0) check({tag, "_first_pc_plus4"}, pop_log[0], (tgt & ~32'h3) + 32'd4);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          first_valid;
    int          b;
    int          n0;
    logic [31:0] saved;
    logic [31:0] tgt;
    logic        redir;

    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; out_ready_i = 1'b0;
    epoch = 0; hs_total = 0; mem_pending = 1'b0; mem_wait = 0; pend_addr = '0; pend_epoch = 0;
    exp_next = RESET_PC; prev_stall = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    rdy_pct = 100; ordy_pct = 0; lat_lo = 1; lat_hi = 1;
    @(negedge clk_i);
    do_reset();

    // Fill with decode stalled: first valid 3 cycles after release, queue saturates.
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid_o && first_valid < 0) first_valid = i;
      step(1'b0, 32'h0);
    end
    check("first_valid_cycle", 32'(first_valid), 32'd3);
    check("fill_hs_count", 32'(hs_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_log.size()) check("fill_req_addr", hs_log[i], RESET_PC + 32'(4 * i));
    end
    check("full_count", 32'(count_o), 32'(DEPTH));
    check("full_req_low", 32'(imem_req_o), 32'h0);

    // Release decode: four back-to-back pops, then fetch resumes at 0x10.
    ordy_pct = 100;
    hs_log.delete();
    pop_log.delete();
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(out_valid_o), 32'h1);
      step(1'b0, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) check("drain_pc_plus4", pop_log[i], 32'(4 * (i + 1)));
    end
    wait_hs(1);
    if (hs_log.size() > 0) check("resume_addr", hs_log[0], 32'h10);

    // Redirect while waiting on the 0x8 response.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    b = 0;
    while (!(mem_pending && pend_addr == 32'h8) && b < 100) begin
      step(1'b0, 32'h0);
      b++;
    end
    check("wait_for_0x8", 32'(mem_pending && pend_addr == 32'h8), 32'h1);
    redirect_check(32'h40, "redir_wait");

    // Redirect coinciding with rvalid.
    lat_lo = 1; lat_hi = 1;
    b = 0;
    while (!(mem_pending && mem_wait == 0) && b < 100) begin
      step(1'b0, 32'h0);
      b++;
    end
    redirect_check(32'h100, "redir_rvalid");

    // Redirect coinciding with a request handshake.
    b = 0;
    while (!imem_req_o && b < 100) begin
      step(1'b0, 32'h0);
      b++;
    end
    check("req_seen", 32'(imem_req_o), 32'h1);
    redirect_check(32'h200, "redir_req_hs");

    // Memory not ready for 5 cycles: request held, exactly one acceptance.
    rdy_pct = 0;
    b = 0;
    while (!imem_req_o && b < 100) begin
      step(1'b0, 32'h0);
      b++;
    end
    saved = imem_addr_o;
    n0    = hs_total;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(imem_req_o), 32'h1);
      check("stall_addr", imem_addr_o, saved);
      step(1'b0, 32'h0);
    end
    rdy_pct = 100;
    step(1'b0, 32'h0);
    check("stall_one_accept", 32'(hs_total - n0), 32'h1);

    // PC wrap at the top of the address space.
    redirect_check(32'hFFFF_FFFC, "redir_wrap");
    wait_hs(2);
    if (hs_log.size() > 1) check("wrap_second_addr", hs_log[1], 32'h0);

    // Randomized traffic with redirects, memory stalls, decode stalls and a mid-run reset.
    rdy_pct = 70; ordy_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      redir = ($urandom_range(99) < 4);
      tgt   = $urandom();
      step(redir, tgt);
      if (i == 400) do_reset();
    end

    rdy_pct = 100; ordy_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (40) step(1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
